// File: rtl/gnss_search_engine.sv
// Acquisition search sequencer: sweeps a Doppler x code-phase grid for one SV.
// Each cell goes to an external correlator. The strongest cell is reported back.
module gnss_search_engine #(
    parameter int unsigned SV_W       = 6,
    parameter int unsigned MAG_W      = 32,
    parameter int          DOP_MIN    = -5000,
    parameter int          DOP_STEP   = 500,
    parameter int unsigned DOP_BINS   = 21,
    parameter int unsigned CODE_STEPS = 2046
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              search_start_i,
    input  logic [SV_W-1:0]   search_sv_i,
    output logic              search_busy_o,
    output logic [31:0]       search_dop_o,
    output logic [31:0]       search_code_o,
    output logic [MAG_W-1:0]  search_peak_o,
    output logic              corr_start_o,
    output logic [SV_W-1:0]   corr_sv_o,
    output logic [31:0]       corr_dop_o,
    output logic [31:0]       corr_code_o,
    input  logic              corr_done_i,
    input  logic [MAG_W-1:0]  corr_mag_i
);

    localparam int unsigned DW = (DOP_BINS > 1) ? $clog2(DOP_BINS) : 1;
    localparam int unsigned CW = (CODE_STEPS > 1) ? $clog2(CODE_STEPS) : 1;
    localparam logic [DW-1:0] DOP_LAST  = DW'(DOP_BINS - 1);
    localparam logic [CW-1:0] CODE_LAST = CW'(CODE_STEPS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e             state_q, state_d;
    logic [SV_W-1:0]    sv_q, sv_d;
    logic [DW-1:0]      dop_idx_q, dop_idx_d;
    logic [CW-1:0]      code_idx_q, code_idx_d;
    logic [31:0]        corr_dop_q, corr_dop_d;
    logic [31:0]        corr_code_q, corr_code_d;
    logic [MAG_W-1:0]   best_mag_q, best_mag_d;
    logic [31:0]        best_dop_q, best_dop_d;
    logic [31:0]        best_code_q, best_code_d;
    logic [31:0]        res_dop_q, res_dop_d;
    logic [31:0]        res_code_q, res_code_d;
    logic [MAG_W-1:0]   res_peak_q, res_peak_d;
    logic               busy_q, busy_d;

    // Next-state logic: sweep sequencing, peak tracking and result publication.
    always_comb begin
        state_d     = state_q;
        sv_d        = sv_q;
        dop_idx_d   = dop_idx_q;
        code_idx_d  = code_idx_q;
        corr_dop_d  = corr_dop_q;
        corr_code_d = corr_code_q;
        best_mag_d  = best_mag_q;
        best_dop_d  = best_dop_q;
        best_code_d = best_code_q;
        res_dop_d   = res_dop_q;
        res_code_d  = res_code_q;
        res_peak_d  = res_peak_q;

        case (state_q)
            IDLE: begin
                if (search_start_i) begin
                    sv_d        = search_sv_i;
                    dop_idx_d   = '0;
                    code_idx_d  = '0;
                    corr_dop_d  = DOP_MIN;
                    corr_code_d = '0;
                    best_mag_d  = '0;
                    best_dop_d  = '0;
                    best_code_d = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (corr_done_i) begin
                    // Strict compare: on ties the earlier cell wins.
                    if (corr_mag_i > best_mag_q) begin
                        best_mag_d  = corr_mag_i;
                        best_dop_d  = corr_dop_q;
                        best_code_d = corr_code_q;
                    end
                    if (dop_idx_q == DOP_LAST && code_idx_q == CODE_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        if (code_idx_q == CODE_LAST) begin
                            code_idx_d = '0;
                            dop_idx_d  = dop_idx_q + 1'b1;
                            // Running sum keeps the bin frequency without a multiplier.
                            corr_dop_d = corr_dop_q + DOP_STEP;
                        end else begin
                            code_idx_d = code_idx_q + 1'b1;
                        end
                        corr_code_d = 32'(code_idx_d);
                    end
                end
            end
            DONE: begin
                res_dop_d  = best_dop_q;
                res_code_d = best_code_q;
                res_peak_d = best_mag_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Busy stays up one cycle past DONE so results are stable before it falls.
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sv_q        <= '0;
            dop_idx_q   <= '0;
            code_idx_q  <= '0;
            corr_dop_q  <= '0;
            corr_code_q <= '0;
            best_mag_q  <= '0;
            best_dop_q  <= '0;
            best_code_q <= '0;
            res_dop_q   <= '0;
            res_code_q  <= '0;
            res_peak_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sv_q        <= sv_d;
            dop_idx_q   <= dop_idx_d;
            code_idx_q  <= code_idx_d;
            corr_dop_q  <= corr_dop_d;
            corr_code_q <= corr_code_d;
            best_mag_q  <= best_mag_d;
            best_dop_q  <= best_dop_d;
            best_code_q <= best_code_d;
            res_dop_q   <= res_dop_d;
            res_code_q  <= res_code_d;
            res_peak_q  <= res_peak_d;
            busy_q      <= busy_d;
        end
    end

    assign search_busy_o = busy_q;
    assign search_dop_o  = res_dop_q;
    assign search_code_o = res_code_q;
    assign search_peak_o = res_peak_q;
    assign corr_start_o  = (state_q == ISSUE);
    assign corr_sv_o     = sv_q;
    assign corr_dop_o    = corr_dop_q;
    assign corr_code_o   = corr_code_q;

endmodule

// File: tb/tb_gnss_search_engine.sv
// Scoreboard bench for gnss_search_engine on a 3 x 4 grid.
module tb_gnss_search_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        search_start;
    logic [5:0]  search_sv;
    logic        search_busy;
    logic [31:0] search_dop, search_code, search_peak;
    logic        corr_start;
    logic [5:0]  corr_sv;
    logic [31:0] corr_dop, corr_code;
    logic        corr_done;
    logic [31:0] corr_mag;

    gnss_search_engine #(
        .SV_W(6), .MAG_W(32), .DOP_MIN(-500), .DOP_STEP(500),
        .DOP_BINS(3), .CODE_STEPS(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .search_start_i(search_start), .search_sv_i(search_sv),
        .search_busy_o(search_busy), .search_dop_o(search_dop),
        .search_code_o(search_code), .search_peak_o(search_peak),
        .corr_start_o(corr_start), .corr_sv_o(corr_sv),
        .corr_dop_o(corr_dop), .corr_code_o(corr_code),
        .corr_done_i(corr_done), .corr_mag_i(corr_mag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  sv;
        logic [31:0] dop;
        logic [31:0] code;
    } cell_t;

    typedef struct {
        logic [31:0] dop;
        logic [31:0] code;
        logic [31:0] peak;
        int          len;
    } res_t;

    cell_t cell_q[$];
    res_t  res_q[$];
    int    cmp_cnt = 0;
    int    err_cnt = 0;
    int    res_seen = 0;
    bit    abort_pend = 0;
    int    lat = 1;
    bit    spur_en = 0;
    logic [31:0] mag_tbl [3][4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lookup(input logic [31:0] dop, input logic [31:0] code);
        int d;
        d = $signed(dop);
        if (d < -500 || d > 500 || code > 32'd3) return 32'd0;
        return mag_tbl[(d + 500) / 500][code[1:0]];
    endfunction

    task automatic fill(input logic [31:0] v);
        for (int b = 0; b < 3; b++)
            for (int c = 0; c < 4; c++)
                mag_tbl[b][c] = v;
    endtask

    // Expected issue order: code inner, Doppler outer, starting at -500 Hz.
    task automatic push_cells(input logic [5:0] sv);
        cell_t c;
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 4; k++) begin
                c.sv = sv; c.dop = 32'(-500 + 500 * b); c.code = 32'(k);
                cell_q.push_back(c);
            end
    endtask

    task automatic wait_result(input int tgt);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (res_seen >= tgt) return;
        end
        cmp_cnt++; err_cnt++;
        $display("FAIL search_timeout: got no completion want completion");
    endtask

    task automatic run_search(input logic [5:0] sv, input logic [31:0] edop, input logic [31:0] ecode,
                              input logic [31:0] epeak, input int elen, input bit poke);
        res_t r;
        int   tgt;
        push_cells(sv);
        r = '{edop, ecode, epeak, elen};
        res_q.push_back(r);
        tgt = res_seen + 1;
        @(negedge clk); search_start = 1'b1; search_sv = sv;
        @(negedge clk); search_start = 1'b0;
        if (poke) begin
            repeat (5) @(negedge clk);
            search_start = 1'b1; search_sv = 6'd9;
            @(negedge clk); search_start = 1'b0;
        end
        wait_result(tgt);
        check("corr_start_count_left", 32'(cell_q.size()), 32'd0);
    endtask

    // Correlator model: done L cycles after start, optional spurious done during ISSUE.
    initial begin
        int cnt;
        logic [31:0] pend;
        cnt = 0; pend = '0;
        corr_done = 1'b0; corr_mag = '0;
        forever begin
            @(negedge clk);
            corr_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin corr_done = 1'b1; corr_mag = pend; end
            end
            if (corr_start === 1'b1) begin
                cnt  = lat;
                pend = lookup(corr_dop, corr_code);
                if (spur_en) begin corr_done = 1'b1; corr_mag = 32'd1000; end
            end
        end
    end

    // Monitor: checks every issued cell and every completed search against the queues.
    initial begin
        cell_t c;
        res_t  r;
        int    blen;
        logic  busy_prev;
        blen = 0; busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (corr_start === 1'b1) begin
                cmp_cnt++;
                if (cell_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL unexpected_corr_start: got dop=%0h code=%0h want none", corr_dop, corr_code);
                end else begin
                    c = cell_q.pop_front();
                    if (corr_sv !== c.sv || corr_dop !== c.dop || corr_code !== c.code) begin
                        err_cnt++;
                        $display("FAIL cell: got sv=%0d dop=%0h code=%0h want sv=%0d dop=%0h code=%0h",
                                 corr_sv, corr_dop, corr_code, c.sv, c.dop, c.code);
                    end
                end
            end
            if (search_busy === 1'b1) blen++;
            if (busy_prev === 1'b1 && search_busy === 1'b0) begin
                if (abort_pend) begin
                    abort_pend = 0;
                end else begin
                    cmp_cnt++;
                    if (res_q.size() == 0) begin
                        err_cnt++;
                        $display("FAIL unexpected_completion: got busy fall want none");
                    end else begin
                        r = res_q.pop_front();
                        if (search_dop !== r.dop || search_code !== r.code ||
                            search_peak !== r.peak || blen != r.len) begin
                            err_cnt++;
                            $display("FAIL result: got dop=%0h code=%0h peak=%0h len=%0d want dop=%0h code=%0h peak=%0h len=%0d",
                                     search_dop, search_code, search_peak, blen, r.dop, r.code, r.peak, r.len);
                        end
                    end
                    res_seen++;
                end
            end
            if (search_busy !== 1'b1) blen = 0;
            busy_prev = search_busy;
        end
    end

    // Directed stimulus.
    initial begin
        int n;
        rst = 1'b1; search_start = 1'b0; search_sv = '0;
        fill(32'd0);
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(search_busy), 32'd0);
        check("rst_dop", search_dop, 32'd0);
        check("rst_code", search_code, 32'd0);
        check("rst_peak", search_peak, 32'd0);
        check("rst_corr_start", 32'(corr_start), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Peak at (500 Hz, code 1).
        fill(32'd10); mag_tbl[2][1] = 32'd99;
        run_search(6'd7, 32'd500, 32'd1, 32'd99, 26, 1'b0);

        // Tie between (-500,3) and (0,0): earlier cell kept.
        fill(32'd5); mag_tbl[0][3] = 32'd50; mag_tbl[1][0] = 32'd50;
        run_search(6'd7, 32'hFFFFFE0C, 32'd3, 32'd50, 26, 1'b0);

        // Start pulse and SV change while busy are ignored, then a fresh sv=9 sweep.
        fill(32'd10); mag_tbl[2][1] = 32'd99;
        run_search(6'd7, 32'd500, 32'd1, 32'd99, 26, 1'b1);
        run_search(6'd9, 32'd500, 32'd1, 32'd99, 26, 1'b0);

        // All-zero grid reports the cleared best cell.
        fill(32'd0);
        run_search(6'd3, 32'd0, 32'd0, 32'd0, 26, 1'b0);

        // Five-cycle correlator latency with spurious done during ISSUE.
        fill(32'd10); mag_tbl[2][1] = 32'd99;
        lat = 5; spur_en = 1;
        run_search(6'd7, 32'd500, 32'd1, 32'd99, 74, 1'b0);
        lat = 1; spur_en = 0;

        // Reset at the 6th corr_start; the late done must be ignored.
        push_cells(6'd7);
        @(negedge clk); search_start = 1'b1; search_sv = 6'd7;
        @(negedge clk); search_start = 1'b0;
        n = 0;
        for (int k = 0; k < 200 && n < 6; k++) begin
            if (corr_start === 1'b1) n++;
            if (n < 6) @(negedge clk);
        end
        check("mid_rst_reached_6th_start", 32'(n), 32'd6);
        abort_pend = 1; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        cell_q.delete();
        check("mid_rst_busy", 32'(search_busy), 32'd0);
        check("mid_rst_dop", search_dop, 32'd0);
        check("mid_rst_code", search_code, 32'd0);
        check("mid_rst_peak", search_peak, 32'd0);
        check("mid_rst_corr_start", 32'(corr_start), 32'd0);
        check("mid_rst_corr_dop", corr_dop, 32'd0);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (search_busy !== 1'b0 || corr_start !== 1'b0) n++;
        end
        check("mid_rst_stays_idle", 32'(n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
